// File: rtl/imm_extend_unit.sv
// Immediate extension unit: extends a raw immediate by mode at input acceptance and holds
// results in a 2-entry in-order buffer with valid/ready handshakes on both sides.
module imm_extend_unit #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic [2:0]       in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_err_o,
    output logic [15:0]      ext_count_o
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   head_data_q, head_data_d;
    logic [OUT_W-1:0]   tail_data_q, tail_data_d;
    logic               head_err_q, head_err_d;
    logic               tail_err_q, tail_err_d;
    logic [15:0]        count_q, count_d;

    logic               push, pop;
    logic [OUT_W-1:0]   sext_full, zext_full, sext_byte, zext_byte;
    logic [OUT_W-1:0]   ext_data;
    logic               ext_err;

    // Extension of the offered immediate; only captured when the entry is accepted.
    always_comb begin
        sext_full = OUT_W'($signed(in_data_i));
        zext_full = OUT_W'(in_data_i);
        sext_byte = OUT_W'($signed(in_data_i[7:0]));
        zext_byte = OUT_W'(in_data_i[7:0]);
        ext_data  = '0;
        ext_err   = 1'b0;
        case (in_mode_i)
            3'd0:    ext_data = sext_full;
            3'd1:    ext_data = zext_full;
            3'd2:    ext_data = zext_full << (OUT_W - IN_W);
            3'd3:    ext_data = sext_byte;
            3'd4:    ext_data = zext_byte;
            3'd5:    ext_data = sext_full << 2;
            default: begin
                ext_data = '0;
                ext_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StEmpty;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_err_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_err_q  <= tail_err_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;
        count_d     = pop ? count_q + 16'd1 : count_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    head_data_d = ext_data;
                    head_err_d  = ext_err;
                    state_d     = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    // Head drains while the new entry takes its place.
                    head_data_d = ext_data;
                    head_err_d  = ext_err;
                end else if (push) begin
                    tail_data_d = ext_data;
                    tail_err_d  = ext_err;
                    state_d     = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                    state_d     = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Outputs come from registered state only, so in_ready_o never sees out_ready_i.
    always_comb begin
        in_ready_o  = (state_q != StFull);
        out_valid_o = (state_q != StEmpty);
        out_data_o  = head_data_q;
        out_err_o   = head_err_q;
        ext_count_o = count_q;
    end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter IN_W, default 16, width of the immediate field presented on InData.
REQ-002 Parameter OUT_W, default 32, width of the extended result; legal only when OUT_W >= IN_W >= 8.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 InValid  input  1  producer offers InData/InMode this cycle.
REQ-006 InReady  output  1  unit can accept an entry this cycle.
REQ-007 InData  input  IN_W  raw immediate field.
REQ-008 InMode  input  3  extension mode select (REQ-013).
REQ-009 OutValid  output  1  OutData/OutErr hold a valid result.
REQ-010 OutReady  input  1  consumer accepts the result this cycle.
REQ-011 OutData  output  OUT_W  extended result.
REQ-012 OutErr  output  1  result was produced from a reserved mode; ExtCount  output  16  count of completed output handshakes.

Function
REQ-013 Modes: 0 SEXT (replicate InData[IN_W-1]); 1 ZEXT; 2 UPPER ({InData, OUT_W-IN_W zeros}); 3 SEXT8 (sign-extend InData[7:0]); 4 ZEXT8 (zero-extend InData[7:0]); 5 BRANCH (SEXT result shifted left 2, top two bits discarded, low two bits 0); 6,7 reserved.
REQ-014 Reserved modes SHALL produce OutData = 0 with OutErr = 1; all other modes OutErr = 0.
REQ-015 When OUT_W == IN_W, modes 0, 1 and 2 SHALL all return InData unchanged.
REQ-016 Input handshake completes when InValid && InReady at a rising Clk edge; output handshake completes when OutValid && OutReady.
REQ-017 Extension SHALL be computed at input acceptance and stored with its OutErr flag; the stored value SHALL not change while held.
REQ-018 Storage is a 2-entry in-order buffer; state machine EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
REQ-019 InReady = 1 in EMPTY and ONE, 0 in FULL; InReady SHALL depend only on registered state, never combinationally on OutReady.
REQ-020 OutValid = 1 in ONE and FULL; OutData/OutErr SHALL present the oldest stored entry.
REQ-021 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE stays ONE on simultaneous push and pop (new entry becomes head next cycle); FULL->ONE on pop; all other cases hold state.
REQ-022 Latency SHALL be exactly 1 cycle: an entry accepted at edge N into EMPTY is on OutData with OutValid = 1 after edge N.
REQ-023 Sustained throughput SHALL be one result per cycle when InValid and OutReady are held high.
REQ-024 Output SHALL be stable (OutData, OutErr, OutValid unchanged) while OutValid && !OutReady.
REQ-025 ExtCount SHALL increment by 1 per output handshake and wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-026 Inputs presented while InReady = 0 SHALL be ignored; no entry is dropped or duplicated.

Reset
REQ-027 Reset assertion SHALL immediately force state EMPTY, OutValid = 0, OutData = 0, OutErr = 0, ExtCount = 0, InReady = 1, independent of Clk.
REQ-028 Reset mid-operation SHALL discard all buffered entries; no stale entry SHALL appear after deassertion.
REQ-029 First input acceptance SHALL be possible on the first rising Clk edge after Reset deasserts.

Verification
REQ-030 Modes, IN_W=16/OUT_W=32, OutReady=1: InData 16'h8001 mode 0 -> 32'hFFFF8001; mode 1 -> 32'h00008001; mode 2 -> 32'h80010000; mode 5 -> 32'hFFFE0004; InData 16'h00F0 mode 3 -> 32'hFFFFFFF0; mode 4 -> 32'h000000F0; mode 6 -> OutData 0, OutErr 1.
REQ-031 Back-pressure: OutReady=0, push 16'h0001 then 16'h0002 -> InReady 0 after second edge, third offer 16'h0003 ignored; OutReady=1 -> 32'h1 then 32'h2 in order, then EMPTY.
REQ-032 Streaming: InValid=OutReady=1 for 10 cycles with InData 0..9 mode 1 -> OutValid high from cycle 1, outputs 0..9 in order one per cycle, ExtCount = 10.
REQ-033 Simultaneous push/pop in ONE with OutReady toggling randomly for 1000 entries -> output sequence equals input sequence, no loss or duplication, stability per REQ-024 every stalled cycle.
REQ-034 Reset in FULL with entries pending -> OutValid 0, ExtCount 0 immediately without a Clk edge; after deassertion first output is the first post-reset input.
REQ-035 Wrap: preload 65535 handshakes then one more -> ExtCount reads 16'h0000; parameter sweep IN_W=OUT_W=16 mode 0/1/2 on 16'hA5A5 -> 16'hA5A5.
